// File: rtl/register_file_onehot.sv
`default_nettype none
// ============================================================================
// Module      : register_file_onehot
// Description : 32 x DATA_WIDTH MIPS general register file with a one-hot
//               write strobe, two combinational read ports, optional
//               same-cycle write bypass, a saturating write counter and a
//               sticky multi-hot enable fault flag. Register $0 reads zero.
// Revision    : 1.0 - initial release
// ============================================================================
module register_file_onehot #(
    parameter int                       DATA_WIDTH  = 32,
    parameter int                       BYPASS      = 1,
    parameter logic [DATA_WIDTH-1:0]    RESET_VALUE = '0
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic [31:0]             WriteEnable,
    input  logic [DATA_WIDTH-1:0]   WriteData,
    input  logic [4:0]              ReadRegister1,
    input  logic [4:0]              ReadRegister2,
    output logic [DATA_WIDTH-1:0]   ReadData1,
    output logic [DATA_WIDTH-1:0]   ReadData2,
    output logic [15:0]             WriteCount,
    output logic                    MultiHotError
);

    localparam logic [15:0] C_COUNT_MAX = 16'hFFFF;

    // Storage for registers 1..31; $0 has no storage at all.
    logic [DATA_WIDTH-1:0] regs_q [1:31];
    logic [15:0]           count_q;
    logic [15:0]           count_d;
    logic                  mh_err_q;
    logic                  mh_err_d;

    logic [5:0]            w_pop;
    logic                  w_one_hot;
    logic                  w_multi_hot;
    logic [DATA_WIDTH-1:0] w_rd1;
    logic [DATA_WIDTH-1:0] w_rd2;

    // Population count of WriteEnable[31:1]: separates none / one / many.
    // An X on any enable bit makes the comparisons X, which the if-statements
    // below treat as false, so no register is disturbed in simulation.
    always_comb begin
        w_pop = '0;
        for (int k = 1; k < 32; k++) begin
            w_pop = w_pop + 6'(WriteEnable[k]);
        end
        w_one_hot   = (w_pop == 6'd1);
        w_multi_hot = (w_pop > 6'd1);
    end

    // Next state of the write counter (saturating) and sticky fault flag.
    always_comb begin
        count_d  = count_q;
        mh_err_d = mh_err_q;
        if (w_one_hot && (count_q != C_COUNT_MAX)) begin
            count_d = count_q + 16'd1;
        end
        if (w_multi_hot) begin
            mh_err_d = 1'b1;
        end
    end

    // Register array: commit only on a strictly one-hot strobe.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            for (int k = 1; k < 32; k++) begin
                regs_q[k] <= RESET_VALUE;
            end
        end else begin
            for (int k = 1; k < 32; k++) begin
                if (w_one_hot && WriteEnable[k]) begin
                    regs_q[k] <= WriteData;
                end
            end
        end
    end

    // Counter and fault flag state.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            count_q  <= '0;
            mh_err_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            mh_err_q <= mh_err_d;
        end
    end

    // Read port 1: stored value, overridden by WriteData on a legal write to
    // the same register when bypass is enabled. Bypass is suppressed during
    // reset because the write it would forward can never commit.
    always_comb begin
        w_rd1 = '0;
        for (int k = 1; k < 32; k++) begin
            if (ReadRegister1 == 5'(k)) begin
                w_rd1 = regs_q[k];
            end
        end
        if ((BYPASS != 0) && !Reset && w_one_hot &&
            (ReadRegister1 != 5'd0) && WriteEnable[ReadRegister1]) begin
            w_rd1 = WriteData;
        end
    end

    // Read port 2: identical structure to port 1.
    always_comb begin
        w_rd2 = '0;
        for (int k = 1; k < 32; k++) begin
            if (ReadRegister2 == 5'(k)) begin
                w_rd2 = regs_q[k];
            end
        end
        if ((BYPASS != 0) && !Reset && w_one_hot &&
            (ReadRegister2 != 5'd0) && WriteEnable[ReadRegister2]) begin
            w_rd2 = WriteData;
        end
    end

    assign ReadData1     = w_rd1;
    assign ReadData2     = w_rd2;
    assign WriteCount    = count_q;
    assign MultiHotError = mh_err_q;

endmodule
`default_nettype wire

// File: tb/tb_register_file_onehot.sv
`default_nettype none
// ============================================================================
// Module      : tb_register_file_onehot
// Description : Scoreboard bench for register_file_onehot. Two instances
//               (bypass on / bypass off) share all inputs. Stimulus pushes
//               expected values; a monitor pops and compares at each falling
//               clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_register_file_onehot;

    logic        Clock;
    logic        Reset;
    logic [31:0] WriteEnable;
    logic [31:0] WriteData;
    logic [4:0]  ReadRegister1;
    logic [4:0]  ReadRegister2;
    logic [31:0] ReadData1_b, ReadData2_b, ReadData1_n, ReadData2_n;
    logic [15:0] WriteCount_b, WriteCount_n;
    logic        MultiHotError_b, MultiHotError_n;

    register_file_onehot #(.DATA_WIDTH(32), .BYPASS(1), .RESET_VALUE(32'h0)) dut (
        .Clock(Clock), .Reset(Reset), .WriteEnable(WriteEnable), .WriteData(WriteData),
        .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
        .ReadData1(ReadData1_b), .ReadData2(ReadData2_b),
        .WriteCount(WriteCount_b), .MultiHotError(MultiHotError_b)
    );

    register_file_onehot #(.DATA_WIDTH(32), .BYPASS(0), .RESET_VALUE(32'h0)) dut_nb (
        .Clock(Clock), .Reset(Reset), .WriteEnable(WriteEnable), .WriteData(WriteData),
        .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
        .ReadData1(ReadData1_n), .ReadData2(ReadData2_n),
        .WriteCount(WriteCount_n), .MultiHotError(MultiHotError_n)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // Observable selectors
    localparam int S_RD1_B = 0, S_RD2_B = 1, S_CNT_B = 2, S_MH_B = 3;
    localparam int S_RD1_N = 4, S_RD2_N = 5, S_CNT_N = 6, S_MH_N = 7;

    typedef struct {
        int          sel;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t q[$];
    int   compared   = 0;
    int   mismatched = 0;

    // Monitor: every falling edge, drain and check all pending expectations.
    always @(negedge Clock) begin
        while (q.size() > 0) begin
            exp_t        e;
            logic [31:0] act;
            e = q.pop_front();
            case (e.sel)
                S_RD1_B: act = ReadData1_b;
                S_RD2_B: act = ReadData2_b;
                S_CNT_B: act = {16'h0, WriteCount_b};
                S_MH_B:  act = {31'h0, MultiHotError_b};
                S_RD1_N: act = ReadData1_n;
                S_RD2_N: act = ReadData2_n;
                S_CNT_N: act = {16'h0, WriteCount_n};
                default: act = {31'h0, MultiHotError_n};
            endcase
            compared++;
            if (act !== e.exp) begin
                mismatched++;
                $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
            end
        end
    end

    task automatic expect_val(input int sel, input logic [31:0] v, input string name);
        exp_t e;
        e.sel  = sel;
        e.exp  = v;
        e.name = name;
        q.push_back(e);
    endtask

    // Advance to just after the next rising edge, where inputs are driven.
    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic drive(input logic [31:0] we, input logic [31:0] wd,
                         input logic [4:0] r1, input logic [4:0] r2);
        WriteEnable   = we;
        WriteData     = wd;
        ReadRegister1 = r1;
        ReadRegister2 = r2;
    endtask

    initial begin
        logic [31:0] v1, v2;
        Reset = 1'b1;
        drive(32'h0, 32'h0, 5'd5, 5'd31);

        // Reset state
        step();
        expect_val(S_RD1_B, 32'h0, "reset_rd1");
        expect_val(S_RD2_B, 32'h0, "reset_rd2");
        expect_val(S_CNT_B, 32'h0, "reset_count");
        expect_val(S_MH_B,  32'h0, "reset_mh");
        step();
        step();
        Reset = 1'b0;

        // Single write to $5, bypass visible before the edge only on dut
        drive(32'h0000_0020, 32'hDEAD_BEEF, 5'd5, 5'd0);
        expect_val(S_RD1_B, 32'hDEAD_BEEF, "wr5_bypass_pre");
        expect_val(S_RD1_N, 32'h0,         "wr5_nobypass_pre");
        step();
        drive(32'h0, 32'h0, 5'd5, 5'd5);
        expect_val(S_RD1_B, 32'hDEAD_BEEF, "wr5_readback");
        expect_val(S_RD2_N, 32'hDEAD_BEEF, "wr5_readback_nb");
        expect_val(S_CNT_B, 32'd1,         "wr5_count");

        // $0 is hardwired to zero
        step();
        drive(32'h0000_0001, 32'hFFFF_FFFF, 5'd0, 5'd0);
        expect_val(S_RD1_B, 32'h0, "r0_pre_rd1");
        expect_val(S_RD2_B, 32'h0, "r0_pre_rd2");
        step();
        drive(32'h0, 32'h0, 5'd0, 5'd0);
        expect_val(S_RD1_B, 32'h0, "r0_rd1");
        expect_val(S_RD2_N, 32'h0, "r0_rd2_nb");
        expect_val(S_CNT_B, 32'd1, "r0_count_unchanged");

        // Bypass vs no bypass on $7
        step();
        drive(32'h0000_0080, 32'h1111_1111, 5'd0, 5'd0);
        step();
        drive(32'h0000_0080, 32'h2222_2222, 5'd7, 5'd7);
        expect_val(S_RD1_B, 32'h2222_2222, "byp_on_pre");
        expect_val(S_RD1_N, 32'h1111_1111, "byp_off_pre");
        step();
        drive(32'h0, 32'h0, 5'd7, 5'd7);
        expect_val(S_RD1_B, 32'h2222_2222, "byp_on_post");
        expect_val(S_RD1_N, 32'h2222_2222, "byp_off_post");
        expect_val(S_CNT_N, 32'd3,         "byp_count");

        // Multi-hot fault
        step();
        drive(32'h0000_0002, 32'h0000_0001, 5'd0, 5'd0);
        step();
        drive(32'h0000_0004, 32'h0000_0002, 5'd0, 5'd0);
        step();
        drive(32'h0000_0006, 32'hAAAA_AAAA, 5'd1, 5'd2);
        expect_val(S_RD1_B, 32'h1, "mh_no_bypass_rd1");
        expect_val(S_RD2_B, 32'h2, "mh_no_bypass_rd2");
        expect_val(S_MH_B,  32'h0, "mh_pre_edge");
        step();
        drive(32'h0, 32'h0, 5'd1, 5'd2);
        expect_val(S_RD1_B, 32'h1, "mh_reg1_kept");
        expect_val(S_RD2_N, 32'h2, "mh_reg2_kept");
        expect_val(S_CNT_B, 32'd5, "mh_count_kept");
        expect_val(S_MH_B,  32'h1, "mh_set");
        expect_val(S_MH_N,  32'h1, "mh_set_nb");
        step();
        drive(32'h0000_0008, 32'h0000_0003, 5'd0, 5'd0);
        step();
        drive(32'h0, 32'h0, 5'd3, 5'd0);
        expect_val(S_RD1_B, 32'h3, "legal_after_mh");
        expect_val(S_CNT_B, 32'd6, "count_after_mh");
        expect_val(S_MH_B,  32'h1, "mh_sticky");

        // Reset asserted mid-cycle during a pending write
        step();
        drive(32'h0000_0020, 32'h5555_5555, 5'd5, 5'd3);
        #2;
        Reset = 1'b1;
        expect_val(S_RD1_B, 32'h0, "midrst_rd1");
        expect_val(S_RD2_B, 32'h0, "midrst_rd2");
        expect_val(S_CNT_B, 32'h0, "midrst_count");
        expect_val(S_MH_B,  32'h0, "midrst_mh");
        step();
        expect_val(S_RD1_B, 32'h0, "rst_blocks_write");
        step();
        Reset = 1'b0;
        drive(32'h0, 32'h0, 5'd5, 5'd0);
        expect_val(S_RD1_N, 32'h0, "post_rst_rd1");
        expect_val(S_CNT_B, 32'h0, "post_rst_count");

        // Sweep: write i*0x01010101 to each register
        for (int i = 1; i < 32; i++) begin
            step();
            drive(32'h1 << i, i * 32'h0101_0101, 5'd0, 5'd0);
        end
        step();
        drive(32'h0, 32'h0, 5'd0, 5'd0);
        expect_val(S_CNT_B, 32'd31, "sweep_count");
        for (int a = 0; a < 32; a++) begin
            for (int b = 0; b < 32; b++) begin
                step();
                ReadRegister1 = 5'(a);
                ReadRegister2 = 5'(b);
                v1 = a * 32'h0101_0101;
                v2 = b * 32'h0101_0101;
                expect_val(S_RD1_B, v1, "sweep_rd1");
                expect_val(S_RD2_B, v2, "sweep_rd2");
            end
        end

        // Saturation: 31 + 65503 = 65534, then one more, then a few extra
        step();
        drive(32'h0000_0002, 32'h1234_5678, 5'd0, 5'd0);
        repeat (65503) @(posedge Clock);
        #1;
        drive(32'h0, 32'h0, 5'd1, 5'd0);
        expect_val(S_CNT_B, 32'h0000_FFFE, "count_fffe");
        step();
        drive(32'h0000_0002, 32'hCAFE_F00D, 5'd1, 5'd0);
        repeat (6) @(posedge Clock);
        #1;
        drive(32'h0, 32'h0, 5'd1, 5'd0);
        expect_val(S_CNT_B, 32'h0000_FFFF, "count_saturated");
        expect_val(S_CNT_N, 32'h0000_FFFF, "count_saturated_nb");
        expect_val(S_RD1_B, 32'hCAFE_F00D, "sat_last_write");
        expect_val(S_MH_B,  32'h0, "sat_mh_clear");

        // Bounded wait for the monitor to drain the scoreboard
        repeat (4) @(negedge Clock);
        #1;
        if (q.size() != 0) begin
            compared++;
            mismatched++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/register_file_onehot.md
Name: register_file_onehot

Overview:
- 32 x 32-bit MIPS general register file. It sits directly downstream of the register write-enable decoder and consumes that decoder's one-hot, RegisterWrite-qualified enable bus.
- Provides one synchronous write port and two combinational read ports to the decode/ALU stages.
- Register $0 always reads zero.
- Flags any illegal multi-hot enable pattern so that decoder faults are caught in simulation.

Parameters:
- DATA_WIDTH, 32, width of each register and of the data ports
- BYPASS, 1, 1 = a read of the register being written this cycle returns WriteData; 0 = it returns the old stored value
- RESET_VALUE, 0, value loaded into registers 1..31 on reset

Ports:
- Clock  input  1  rising-edge clock
- Reset  input  1  asynchronous, active-high; clears state immediately
- WriteEnable  input  32  one-hot write strobe from the write-enable decoder; bit 0 is ignored
- WriteData  input  DATA_WIDTH  data to write
- ReadRegister1  input  5  read port 1 address
- ReadRegister2  input  5  read port 2 address
- ReadData1  output  DATA_WIDTH  read port 1 data, combinational
- ReadData2  output  DATA_WIDTH  read port 2 data, combinational
- WriteCount  output  16  number of committed writes since reset; saturates at 16'hFFFF
- MultiHotError  output  1  sticky flag; set when WriteEnable[31:1] has more than one bit high at a clock edge

Behaviour:
- Reset (asynchronous, active-high):
  - registers 1..31 := RESET_VALUE
  - WriteCount := 0
  - MultiHotError := 0
  - all take effect without waiting for a clock edge
  - while Reset is high, writes are blocked and ReadData reflects the reset contents
  - reset asserted mid-write: the write is lost and the register holds RESET_VALUE
- Register 0: no storage. ReadDataN = 0 whenever ReadRegisterN == 0, regardless of WriteEnable[0], WriteData or BYPASS.
- Write commit (rising Clock edge, Reset low), evaluated on WriteEnable[31:1]:
  - exactly one bit k high: reg[k] := WriteData; WriteCount increments unless it is already 16'hFFFF
  - zero bits high: no state change
  - two or more bits high: no register is written; WriteCount unchanged; MultiHotError := 1 and stays 1 until Reset
- Write latency: the new value is visible on a non-bypassed read in the cycle after the edge.
- Read ports:
  - purely combinational from the ReadRegister inputs and stored state
  - zero-cycle latency
  - both ports may address the same register
- Bypass, BYPASS = 1:
  - applies when ReadRegisterN != 0, WriteEnable[ReadRegisterN] == 1 and WriteEnable[31:1] is exactly one-hot
  - ReadDataN = WriteData in the same cycle (write-then-read ordering within one cycle)
  - a multi-hot enable never bypasses; the stored value is returned
- Bypass, BYPASS = 0: the read returns the stored value until the edge.
- One-hot check: a population count on WriteEnable[31:1] that distinguishes zero, one and more than one.
- No X propagation:
  - outputs must be defined after reset even with WriteEnable undriven-low
  - X on WriteEnable in simulation must not corrupt unselected registers

Test Plan:
- Reset:
  - stimulus: assert Reset async mid-cycle, hold 2 cycles with RESET_VALUE=0
  - required: all ReadData = 0, WriteCount = 0, MultiHotError = 0 immediately, before any clock edge
- Single write and read-back:
  - stimulus: WriteEnable = 32'h0000_0020, WriteData = 32'hDEAD_BEEF, one edge; then ReadRegister1 = 5
  - required: ReadData1 = 32'hDEAD_BEEF; WriteCount = 1
- $0 hardwired:
  - stimulus: WriteEnable = 32'h0000_0001, WriteData = 32'hFFFF_FFFF, one edge; then ReadRegister1 = ReadRegister2 = 0
  - required: both read 0; WriteCount = 0
- Bypass, BYPASS = 1:
  - stimulus: reg[7] = 32'h1111_1111; in the same cycle WriteEnable = 32'h0000_0080, WriteData = 32'h2222_2222, ReadRegister1 = 7
  - required: ReadData1 = 32'h2222_2222 before the edge
  - with BYPASS = 0: ReadData1 = 32'h1111_1111 before the edge, 32'h2222_2222 after it
- Multi-hot fault:
  - stimulus: WriteEnable = 32'h0000_0006, WriteData = 32'hAAAA_AAAA, one edge
  - required: reg[1] and reg[2] unchanged; WriteCount unchanged; MultiHotError = 1; it stays 1 after later legal writes until Reset
- Sweep and saturation:
  - stimulus: write i*32'h0101_0101 to each register 1..31, then read all pairs on both ports
  - required: every value matches
  - stimulus: force 65,540 legal writes
  - required: WriteCount = 16'hFFFF
